seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with a one-deep pending buffer
// so that display updates land only on frame boundaries.
module seg7_scan_ctrl #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [15:0] disp_value,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [3:0]  blank_mask,
    input  logic        enable,
    output logic [3:0]  SEG_ANODE,
    output logic [6:0]  SEG_CATHODE,
    output logic        frame_tick
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    dig;
    logic [15:0]   shadow;
    logic [15:0]   pend_val;
    logic          pend;

    logic          slot_end;
    logic          boundary;
    logic          xfer;
    logic [3:0]    nibble;
    logic [6:0]    seg;

    assign disp_ready = ~pend;

    always_comb begin
        slot_end = (presc == PRESC_MAX);
        boundary = enable && slot_end && (dig == 2'd3);
        xfer     = disp_valid && !pend;

        nibble = shadow[3:0];
        case (dig)
            2'd0: nibble = shadow[3:0];
            2'd1: nibble = shadow[7:4];
            2'd2: nibble = shadow[11:8];
            2'd3: nibble = shadow[15:12];
            default: nibble = shadow[3:0];
        endcase

        // Active-low, bit order gfedcba.
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            presc       <= '0;
            dig         <= '0;
            shadow      <= '0;
            pend_val    <= '0;
            pend        <= 1'b0;
            SEG_ANODE   <= '1;
            SEG_CATHODE <= '1;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= boundary;

            if (!enable || blank_mask[dig]) begin
                SEG_ANODE   <= '1;
                SEG_CATHODE <= '1;
            end else begin
                SEG_ANODE   <= ~(4'b0001 << dig);
                SEG_CATHODE <= seg;
            end

            if (!enable) begin
                presc <= '0;
                dig   <= '0;
                if (xfer) begin
                    shadow <= disp_value;
                end
            end else begin
                if (slot_end) begin
                    presc <= '0;
                    dig   <= dig + 2'd1;
                end else begin
                    presc <= presc + 1'b1;
                end

                // A pending value wins the boundary; ready is low then, so no
                // new transfer can collide with it.
                if (boundary) begin
                    if (pend) begin
                        shadow <= pend_val;
                        pend   <= 1'b0;
                    end else if (xfer) begin
                        shadow <= disp_value;
                    end
                end else if (xfer) begin
                    pend_val <= disp_value;
                    pend     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl at CLK_DIV=4: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_seg7_scan_ctrl;

    logic        ACLK;
    logic        ARESET;
    logic [15:0] disp_value;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  blank_mask;
    logic        enable;
    logic [3:0]  SEG_ANODE;
    logic [6:0]  SEG_CATHODE;
    logic        frame_tick;

    seg7_scan_ctrl #(.CLK_DIV(4)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .disp_value (disp_value),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .blank_mask (blank_mask),
        .enable     (enable),
        .SEG_ANODE  (SEG_ANODE),
        .SEG_CATHODE(SEG_CATHODE),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  an;
        logic [6:0]  cat;
        logic        tick;
        logic        rdy;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    bit          done   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic cmp(input string name, input int unsigned c,
                       input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
        end
    endtask

    always @(negedge ACLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stale_entry: expectation for cycle %0d seen at cycle %0d", e.cyc, cyc);
            end else begin
                cmp("anode",   e.cyc, {4'h0, SEG_ANODE},   {4'h0, e.an});
                cmp("cathode", e.cyc, {1'b0, SEG_CATHODE}, {1'b0, e.cat});
                cmp("tick",    e.cyc, {7'h0, frame_tick},  {7'h0, e.tick});
                cmp("ready",   e.cyc, {7'h0, disp_ready},  {7'h0, e.rdy});
            end
        end
    end

    task automatic push_dark(input int unsigned c, input logic rdy);
        exp_t e;
        e.cyc = c; e.an = 4'hF; e.cat = 7'h7F; e.tick = 1'b0; e.rdy = rdy;
        sb.push_back(e);
    endtask

    // Output frame starting at cycle f: 4 slots of 4 cycles, tick on the last.
    task automatic push_frame(input int unsigned f, input logic [15:0] val,
                              input logic [3:0] blank, input int nk,
                              input int lo_from, input int lo_to);
        exp_t e;
        logic [3:0] d;
        for (int k = 0; k < nk; k++) begin
            int s;
            s = k / 4;
            d = val[s*4 +: 4];
            e.cyc  = f + k;
            e.an   = blank[s] ? 4'hF : ~(4'b0001 << s);
            e.cat  = blank[s] ? 7'h7F : seg_tab[d];
            e.tick = (k == 15);
            e.rdy  = !(k >= lo_from && k <= lo_to);
            sb.push_back(e);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) step(1);
    endtask

    initial begin
        int unsigned c0, f, f6, f7, f8, f9;
        ARESET     = 1'b1;
        enable     = 1'b0;
        disp_valid = 1'b0;
        disp_value = 16'h0000;
        blank_mask = 4'h0;

        step(3);
        c0 = cyc;
        ARESET = 1'b0;
        push_dark(c0, 1'b1);

        // Load while dark, then start scanning.
        disp_value = 16'h1234;
        disp_valid = 1'b1;
        step(1);
        disp_valid = 1'b0;
        enable     = 1'b1;
        push_dark(c0 + 1, 1'b1);
        f = c0 + 2;
        push_frame(f,      16'h1234, 4'h0, 16, 1, 0);
        push_frame(f + 16, 16'h1234, 4'h0, 16, 5, 14);

        // Mid-frame load during the digit-1 slot.
        wait_cyc(f + 20);
        disp_value = 16'hABCD;
        disp_valid = 1'b1;
        step(1);
        disp_valid = 1'b0;
        push_frame(f + 32, 16'hABCD, 4'h0, 16, 1, 0);

        // Transfer in the boundary cycle goes straight to the display.
        wait_cyc(f + 46);
        disp_value = 16'h0F0F;
        disp_valid = 1'b1;
        step(1);
        disp_valid = 1'b0;
        push_frame(f + 48, 16'h0F0F, 4'h0, 16, 1, 0);
        push_frame(f + 64, 16'h0F0F, 4'h8, 16, 1, 0);

        wait_cyc(f + 63);
        blank_mask = 4'h8;

        f6 = f + 80;
        push_frame(f6, 16'h0F0F, 4'h0, 6, 1, 0);
        push_dark(f6 + 6, 1'b1);
        push_dark(f6 + 7, 1'b1);
        push_dark(f6 + 8, 1'b1);
        f7 = f6 + 9;
        push_frame(f7, 16'h0F0F, 4'h0, 16, 1, 0);
        f8 = f7 + 16;
        push_frame(f8, 16'h0F0F, 4'h0, 8, 5, 7);
        push_dark(f8 + 8, 1'b1);
        f9 = f8 + 9;
        push_frame(f9, 16'h0000, 4'h0, 16, 1, 0);

        // Drop enable mid digit-1 slot; scan restarts from digit 0.
        wait_cyc(f6 + 5);
        enable = 1'b0;
        step(1);
        blank_mask = 4'h0;
        wait_cyc(f6 + 8);
        enable = 1'b1;

        // Pending value discarded by reset.
        wait_cyc(f8 + 4);
        disp_value = 16'h5555;
        disp_valid = 1'b1;
        step(1);
        disp_valid = 1'b0;
        wait_cyc(f8 + 7);
        ARESET = 1'b1;
        step(1);
        ARESET = 1'b0;

        wait_cyc(f9 + 18);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            n_fail++;
            $display("FAIL watchdog: cycle %0d reached, expected completion", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

endmodule
